avl_host_arbiter: RTL

- Parametrised multi-channel Avalon-MM host: NUM_CH independent CPU-side request channels share one Avalon-MM host port.
- Each channel has a one-entry pending buffer; a round-robin arbiter issues buffered requests on the bus with no idle cycle between transactions.
- Adds byte enables and configurable data and address widths.
- Sits between the core's insn/data/io request interfaces and the interconnect; it replaces one-port-per-channel bus mastering.

---
 rtl/avl_host_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/avl_host_arbiter.sv
// Multi-channel Avalon-MM host: each request channel owns a one-entry buffer,
// and a round-robin arbiter issues buffered requests back to back on one bus.

module avl_host_arbiter_slot #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              done,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              pend,
    output logic              busy,
    output logic              q_write,
    output logic [ADDR_W-1:0] q_addr,
    output logic [DATA_W-1:0] q_wdata,
    output logic [BE_W-1:0]   q_be
);
    // Completion frees the slot in the same cycle, so a back-to-back start is taken.
    assign busy = pend && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            q_write <= 1'b0;
            q_addr  <= '0;
            q_wdata <= '0;
            q_be    <= '0;
        end else if (start && !busy) begin
            pend    <= 1'b1;
            q_write <= write;
            q_addr  <= addr;
            q_wdata <= wdata;
            q_be    <= be;
        end else if (done) begin
            pend    <= 1'b0;
        end
    end
endmodule

module avl_host_arbiter #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_start,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    output logic [NUM_CH-1:0]          req_busy,
    output logic [NUM_CH-1:0]          rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [31:0]                avl_address,
    output logic                       avl_read,
    output logic                       avl_write,
    output logic [DATA_W/8-1:0]        avl_byteenable,
    output logic [DATA_W-1:0]          avl_writedata,
    input  logic [DATA_W-1:0]          avl_readdata,
    input  logic                       avl_waitrequest
);
    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = $clog2(BE_W);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                         state, state_n;
    logic [CH_W-1:0]                g, g_n, last, last_n, win;
    logic                           found, complete;
    logic [NUM_CH-1:0]              pend, done, cand;
    logic [NUM_CH-1:0]              slot_write;
    logic [NUM_CH-1:0][ADDR_W-1:0]  slot_addr;
    logic [NUM_CH-1:0][DATA_W-1:0]  slot_wdata;
    logic [NUM_CH-1:0][BE_W-1:0]    slot_be;
    logic                           rd_n, wr_n;
    logic [31:0]                    addr_n;
    logic [DATA_W-1:0]              wd_n;
    logic [BE_W-1:0]                be_n;

    assign complete  = (state == BUSY) && !avl_waitrequest;
    assign rsp_ready = done;
    assign rsp_data  = avl_readdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign done[i] = complete && (g == CH_W'(i));
        avl_host_arbiter_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (req_start[i]),
            .done    (done[i]),
            .write   (req_write[i]),
            .addr    (req_addr[i*ADDR_W +: ADDR_W]),
            .wdata   (req_wdata[i*DATA_W +: DATA_W]),
            .be      (req_be[i*BE_W +: BE_W]),
            .pend    (pend[i]),
            .busy    (req_busy[i]),
            .q_write (slot_write[i]),
            .q_addr  (slot_addr[i]),
            .q_wdata (slot_wdata[i]),
            .q_be    (slot_be[i])
        );
    end

    // Round robin from last+1; the channel finishing this cycle is not a candidate.
    always_comb begin
        int idx;
        cand  = pend;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state == BUSY) cand[g] = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (cand[CH_W'(idx)]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        g_n     = g;
        last_n  = last;
        rd_n    = avl_read;
        wr_n    = avl_write;
        addr_n  = avl_address;
        wd_n    = avl_writedata;
        be_n    = avl_byteenable;
        if (state == IDLE || complete) begin
            if (found) begin
                state_n = BUSY;
                g_n     = win;
                last_n  = win;
                rd_n    = !slot_write[win];
                wr_n    = slot_write[win];
                addr_n  = 32'(slot_addr[win]) << OFF;
                wd_n    = slot_wdata[win];
                be_n    = slot_be[win];
            end else begin
                state_n = IDLE;
                rd_n    = 1'b0;
                wr_n    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            g              <= '0;
            last           <= CH_W'(NUM_CH - 1);
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_address    <= '0;
            avl_writedata  <= '0;
            avl_byteenable <= '0;
        end else begin
            state          <= state_n;
            g              <= g_n;
            last           <= last_n;
            avl_read       <= rd_n;
            avl_write      <= wr_n;
            avl_address    <= addr_n;
            avl_writedata  <= wd_n;
            avl_byteenable <= be_n;
        end
    end
endmodule
